// File: rtl/ita_disp_sched.sv
// Display scheduler for a 12-digit, 14-segment multiplexed display: a frame buffer written
// by two requesters through a round-robin arbiter, scanned one digit at a time.
module ita_disp_sched #(
    parameter int unsigned DWELL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req0,
    input  logic [3:0]  addr0,
    input  logic [5:0]  data0,
    input  logic        req1,
    input  logic [3:0]  addr1,
    input  logic [5:0]  data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [11:0] sel,
    output logic [13:0] segm
);

    localparam int unsigned NDIG       = 12;
    localparam logic [5:0]  CH_SPACE   = 6'd36;
    localparam logic [3:0]  LAST_DIG   = 4'd11;
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    // Port that wins the next tie.
    typedef enum logic {
        PRI_P0,
        PRI_P1
    } pri_t;

    pri_t        pri;
    pri_t        pri_next;
    logic [5:0]  fb [NDIG];
    logic [3:0]  dig;
    logic [15:0] cnt;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [5:0]  wr_data;

    // Bit order: a b c d e f g1 g2 h i j k l m (MSB = a).
    function automatic logic [13:0] font(input logic [5:0] code);
        case (code)
            6'd0:    font = 14'b11111100001001;
            6'd1:    font = 14'b01100000000000;
            6'd2:    font = 14'b11011011000000;
            6'd3:    font = 14'b11110001000000;
            6'd4:    font = 14'b01100111000000;
            6'd5:    font = 14'b10110111000000;
            6'd6:    font = 14'b10111111000000;
            6'd7:    font = 14'b11100000000000;
            6'd8:    font = 14'b11111111000000;
            6'd9:    font = 14'b11110111000000;
            6'd10:   font = 14'b11101111000000; // A
            6'd11:   font = 14'b11110001010010;
            6'd12:   font = 14'b10011100000000;
            6'd13:   font = 14'b11110000010010;
            6'd14:   font = 14'b10011110000000;
            6'd15:   font = 14'b10001110000000;
            6'd16:   font = 14'b10111101000000;
            6'd17:   font = 14'b01101111000000;
            6'd18:   font = 14'b10010000010010;
            6'd19:   font = 14'b01111000000000;
            6'd20:   font = 14'b00001110001100; // K
            6'd21:   font = 14'b00011100000000;
            6'd22:   font = 14'b01101100101000;
            6'd23:   font = 14'b01101100100100;
            6'd24:   font = 14'b11111100000000;
            6'd25:   font = 14'b11001111000000; // P
            6'd26:   font = 14'b11111100000100;
            6'd27:   font = 14'b11001111000100;
            6'd28:   font = 14'b10110111000000;
            6'd29:   font = 14'b10000000010010;
            6'd30:   font = 14'b01111100000000; // U
            6'd31:   font = 14'b00001100001001;
            6'd32:   font = 14'b01101100000101;
            6'd33:   font = 14'b00000000101101;
            6'd34:   font = 14'b00000000101010;
            6'd35:   font = 14'b10010000001001; // Z
            default: font = 14'b0;             // space and unused codes
        endcase
    endfunction

    // Round-robin only advances when both ports competed.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        pri_next = pri;
        if (req0 && req1) begin
            if (pri == PRI_P0) begin
                gnt0     = 1'b1;
                pri_next = PRI_P1;
            end else begin
                gnt1     = 1'b1;
                pri_next = PRI_P0;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= PRI_P0;
        end else begin
            pri <= pri_next;
        end
    end

    // Out-of-range addresses still consume the grant but leave the buffer alone.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr0;
        wr_data = data0;
        if (gnt0) begin
            wr_en = (addr0 < 4'd12);
        end else if (gnt1) begin
            wr_en   = (addr1 < 4'd12);
            wr_addr = addr1;
            wr_data = data1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                fb[i] <= CH_SPACE;
            end
        end else if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    // Outputs reflect the digit index held before the edge, reading pre-write buffer contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig  <= '0;
            cnt  <= '0;
            sel  <= '0;
            segm <= '0;
        end else if (en) begin
            sel  <= 12'b1 << dig;
            segm <= font(fb[dig]);
            if (cnt == DWELL_LAST) begin
                cnt <= '0;
                dig <= (dig == LAST_DIG) ? '0 : dig + 4'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            sel  <= '0;
            segm <= '0;
        end
    end

endmodule

// File: tb/tb_ita_disp_sched.sv
// Randomized scoreboard bench for ita_disp_sched: two instances (DWELL=1 and DWELL=3)
// share stimulus and are checked against a frame-buffer / enabled-cycle-count model.
module tb_ita_disp_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [3:0]  addr0 = '0;
    logic [3:0]  addr1 = '0;
    logic [5:0]  data0 = '0;
    logic [5:0]  data1 = '0;
    logic        gnt0_a, gnt1_a, gnt0_b, gnt1_b;
    logic [11:0] sel_a, sel_b;
    logic [13:0] segm_a, segm_b;

    ita_disp_sched #(.DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .segm(segm_a)
    );

    ita_disp_sched #(.DWELL(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .segm(segm_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Reference glyphs for the characters the stimulus uses; everything else is blank.
    function automatic logic [13:0] glyph(input int code);
        case (code)
            0:       return 14'b11111100001001;
            2:       return 14'b11011011000000;
            10:      return 14'b11101111000000;
            25:      return 14'b11001111000000;
            default: return 14'b0;
        endcase
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 2;
            2:       return 10;
            3:       return 25;
            4:       return 36;
            default: return int'($urandom_range(37, 63));
        endcase
    endfunction

    // {gnt1, gnt0}; last_tie=1 means port 1 won the previous tie, so port 0 wins the next.
    function automatic logic [1:0] winner(input logic r0, input logic r1, input bit last_tie);
        if (r0 && !r1) return 2'b01;
        if (r1 && !r0) return 2'b10;
        if (r0 && r1)  return last_tie ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    // Model: scan index derived from the number of enabled cycles since reset.
    int          mbuf [12];
    int          n_en;
    bit          last_tie;
    logic [25:0] q_a[$];
    logic [25:0] q_b[$];

    task automatic model_reset();
        for (int i = 0; i < 12; i++) mbuf[i] = 36;
        n_en     = 0;
        last_tie = 1'b1;
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            logic [1:0] w;
            int ia, ib;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (en) begin
                    ia = n_en % 12;
                    ib = (n_en / 3) % 12;
                    q_a.push_back({12'(1) << ia, glyph(mbuf[ia])});
                    q_b.push_back({12'(1) << ib, glyph(mbuf[ib])});
                    n_en++;
                end else begin
                    q_a.push_back('0);
                    q_b.push_back('0);
                end
                w = winner(req0, req1, last_tie);
                if (req0 && req1) last_tie = w[1];
                if (w[0] && addr0 < 4'd12) mbuf[addr0] = int'(data0);
                else if (w[1] && addr1 < 4'd12) mbuf[addr1] = int'(data1);
            end
        end
    end

    // Output monitor: registered outputs compared mid-cycle.
    initial begin
        forever begin
            logic [25:0] ea, eb;
            @(negedge clk);
            if (!rst_n) begin
                ea = '0;
                eb = '0;
            end else begin
                ea = (q_a.size() != 0) ? q_a.pop_front() : 26'b0;
                eb = (q_b.size() != 0) ? q_b.pop_front() : 26'b0;
            end
            check("sel_d1", 32'(sel_a), 32'(ea[25:14]));
            check("segm_d1", 32'(segm_a), 32'(ea[13:0]));
            check("sel_d3", 32'(sel_b), 32'(eb[25:14]));
            check("segm_d3", 32'(segm_b), 32'(eb[13:0]));
        end
    end

    // Grant monitor: inputs settle at the falling edge, grants checked 3 ns later.
    initial begin
        forever begin
            logic [1:0] eg;
            @(negedge clk);
            #3;
            eg = winner(req0, req1, last_tie);
            check("gnt0_d1", 32'(gnt0_a), 32'(eg[0]));
            check("gnt1_d1", 32'(gnt1_a), 32'(eg[1]));
            check("gnt0_d3", 32'(gnt0_b), 32'(eg[0]));
            check("gnt1_d3", 32'(gnt1_b), 32'(eg[1]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write1(input int p, input int a, input int d);
        bit ok = 1'b0;
        if (p == 0) begin req0 = 1'b1; addr0 = 4'(a); data0 = 6'(d); end
        else        begin req1 = 1'b1; addr1 = 4'(a); data1 = 6'(d); end
        for (int k = 0; k < 8 && !ok; k++) begin
            #4;
            ok = (p == 0) ? gnt0_a : gnt1_a;
            @(negedge clk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!ok) fail("write_grant");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int msg [6];
        int a0 [3];
        int a1 [3];
        int d0 [3];
        int d1 [3];
        int i0, i1, k;
        bit p0, p1, found;

        // Reset held, then scan of an all-space buffer.
        idle(4);
        rst_n = 1'b1;
        en    = 1'b1;
        idle(40);

        // "PA2020" written right to left, first character is P at digit 0.
        msg = '{25, 10, 2, 0, 2, 0};
        for (int i = 0; i < 6; i++) write1(0, i, msg[i]);
        idle(40);

        // Contention: both ports hold requests to distinct addresses.
        a0 = '{6, 7, 8};
        a1 = '{9, 10, 11};
        for (int i = 0; i < 3; i++) begin d0[i] = pick(); d1[i] = pick(); end
        i0 = 0;
        i1 = 0;
        for (k = 0; k < 12 && (i0 < 3 || i1 < 3); k++) begin
            req0 = (i0 < 3);
            req1 = (i1 < 3);
            if (i0 < 3) begin addr0 = 4'(a0[i0]); data0 = 6'(d0[i0]); end
            if (i1 < 3) begin addr1 = 4'(a1[i1]); data1 = 6'(d1[i1]); end
            #4;
            if (gnt0_a) i0++;
            if (gnt1_a) i1++;
            @(negedge clk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (i0 < 3 || i1 < 3) fail("contention_done");
        idle(40);

        // Out-of-range address: granted, buffer untouched.
        write1(1, 13, 10);
        idle(40);

        // Random traffic with random enable; requesters hold until granted.
        p0 = 1'b0;
        p1 = 1'b0;
        repeat (300) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0 = 1'b1; addr0 = 4'($urandom_range(0, 15)); data0 = 6'(pick());
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1'b1; addr1 = 4'($urandom_range(0, 15)); data1 = 6'(pick());
            end
            req0 = p0;
            req1 = p1;
            en   = ($urandom_range(0, 7) != 0);
            #4;
            if (gnt0_a) p0 = 1'b0;
            if (gnt1_a) p1 = 1'b0;
            @(negedge clk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        en   = 1'b1;
        idle(4);

        // Enable drop while the DWELL=3 instance shows digit 4, resume 5 cycles later.
        found = 1'b0;
        for (k = 0; k < 60 && !found; k++) begin
            if (sel_b == 12'h010) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) fail("wait_sel_010");
        en = 1'b0;
        idle(5);
        en = 1'b1;
        idle(12);

        // Reset asserted between edges while a write is being granted.
        req0  = 1'b1;
        addr0 = 4'd3;
        data0 = 6'd10;
        #4;
        rst_n = 1'b0;
        #1;
        check("rst_async_sel_d1", 32'(sel_a), 32'h0);
        check("rst_async_segm_d1", 32'(segm_a), 32'h0);
        check("rst_async_sel_d3", 32'(sel_b), 32'h0);
        check("rst_async_segm_d3", 32'(segm_b), 32'h0);
        @(negedge clk);
        req0 = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
